census_stream_ctrl: RTL and testbench

- Frame sequencer in front of the census stereo datapath (line buffers -> census -> tapped FIFO -> popcount -> argmin). That datapath has no enable and consumes one pixel pair per clock.
- This block accepts a left/right pixel stream with start-of-frame. It feeds the datapath a gap-free raster and pads with zeros on underrun and during end-of-frame flush.
- It realigns the datapath's disparity output to raster coordinates and masks border pixels whose window or disparity history is incomplete.

---
 rtl/census_stream_ctrl_pkg.sv | 36 +++
 rtl/census_stream_ctrl_delay_line.sv | 26 ++
 rtl/census_stream_ctrl.sv | 175 +++++++++++++++++
 tb/tb_census_stream_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/census_stream_ctrl_pkg.sv
// Shared constants for the census stereo front end: FSM encoding, sizing helper
// and the border-mask thresholds derived from window and disparity geometry.
package census_stream_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int LINE_LENGTH_DEF   = 640;
    localparam int NUM_LINES_DEF     = 480;
    localparam int WINDOW_WIDTH_DEF  = 20;
    localparam int WINDOW_HEIGHT_DEF = 20;
    localparam int MAX_DISPARITY_DEF = 40;

    // Minimum of 1 so that counters never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // First column whose census window and full disparity history are both valid.
    function automatic int mask_x_min(input int win_w, input int max_disp);
        return win_w + max_disp - 2;
    endfunction

    function automatic int mask_y_min(input int win_h);
        return win_h - 1;
    endfunction

    localparam int MASK_X_MIN_DEF = mask_x_min(WINDOW_WIDTH_DEF, MAX_DISPARITY_DEF);
    localparam int MASK_Y_MIN_DEF = mask_y_min(WINDOW_HEIGHT_DEF);

endpackage

// File: rtl/census_stream_ctrl_delay_line.sv
// Fixed-depth shift register; used to align the "real pixel" flag with the
// datapath's disparity output.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/census_stream_ctrl.sv
// Frame sequencer for the census stereo datapath: gap-free raster feed with zero
// padding, output realignment to raster coordinates and border masking.
module census_stream_ctrl
    import census_stream_ctrl_pkg::*;
#(
    parameter int LINE_LENGTH   = LINE_LENGTH_DEF,
    parameter int NUM_LINES     = NUM_LINES_DEF,
    parameter int WINDOW_WIDTH  = WINDOW_WIDTH_DEF,
    parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
    parameter int MAX_DISPARITY = MAX_DISPARITY_DEF,
    parameter int PIPE_LATENCY  = 4,
    parameter int DISP_BITS     = 6,
    localparam int XW = clog2(LINE_LENGTH),
    localparam int YW = clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [7:0]           in_left,
    input  logic [7:0]           in_right,
    output logic [7:0]           dp_left,
    output logic [7:0]           dp_right,
    input  logic [DISP_BITS-1:0] dp_disp,
    output logic                 out_valid,
    output logic [DISP_BITS-1:0] out_disp,
    output logic                 out_mask,
    output logic [XW-1:0]        out_x,
    output logic [YW-1:0]        out_y,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_underrun,
    output logic                 err_sof
);

    localparam int NPIX  = LINE_LENGTH * NUM_LINES;
    localparam int PW    = clog2(NPIX);
    localparam int FW    = clog2(PIPE_LATENCY + 1);
    localparam int X_MIN = mask_x_min(WINDOW_WIDTH, MAX_DISPARITY);
    localparam int Y_MIN = mask_y_min(WINDOW_HEIGHT);

    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(PIPE_LATENCY);
    localparam logic [XW-1:0] X_LAST   = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(NUM_LINES - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [7:0]    left_q, left_d, right_q, right_d;
    logic          real_q, real_d;
    logic          eu_q, eu_d, es_q, es_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          done_q;
    logic          valid_al;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        fl_d    = fl_q;
        left_d  = '0;
        right_d = '0;
        real_d  = 1'b0;
        eu_d    = eu_q;
        es_d    = es_q;
        case (state_q)
            ST_IDLE: begin
                // Non-sof beats are swallowed here so upstream never stalls.
                if (in_valid && in_sof) begin
                    left_d  = in_left;
                    right_d = in_right;
                    real_d  = 1'b1;
                    pix_d   = PW'(1);
                    eu_d    = 1'b0;
                    es_d    = 1'b0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // The datapath has no enable: a slot is consumed every clock.
                real_d = 1'b1;
                if (in_valid) begin
                    left_d  = in_left;
                    right_d = in_right;
                    if (in_sof) es_d = 1'b1;
                end else begin
                    eu_d = 1'b1;
                end
                if (pix_q == PIX_LAST) begin
                    fl_d    = '0;
                    state_d = ST_FLUSH;
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
            ST_FLUSH: begin
                if (fl_q == FL_LAST) state_d = ST_DONE;
                else                 fl_d    = fl_q + FW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            fl_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
            real_q  <= 1'b0;
            eu_q    <= 1'b0;
            es_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            fl_q    <= fl_d;
            left_q  <= left_d;
            right_q <= right_d;
            real_q  <= real_d;
            eu_q    <= eu_d;
            es_q    <= es_d;
        end
    end

    // real_q lines up with dp_left; PIPE_LATENCY more stages line it up with dp_disp.
    delay_line #(
        .WIDTH (1),
        .DEPTH (PIPE_LATENCY)
    ) u_valid_dly (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (real_q),
        .q_o   (valid_al)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= valid_al && (x_q == X_LAST) && (y_q == Y_LAST);
            if (valid_al) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    assign in_ready     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign busy         = (state_q != ST_IDLE);
    assign dp_left      = left_q;
    assign dp_right     = right_q;
    assign out_valid    = valid_al;
    assign out_x        = x_q;
    assign out_y        = y_q;
    assign out_sof      = valid_al && (x_q == '0) && (y_q == '0);
    assign out_eol      = valid_al && (x_q == X_LAST);
    assign out_mask     = valid_al && (int'(y_q) >= Y_MIN) && (int'(x_q) >= X_MIN);
    assign out_disp     = out_mask ? dp_disp : '0;
    assign frame_done   = done_q;
    assign err_underrun = eu_q;
    assign err_sof      = es_q;

endmodule

// File: tb/tb_census_stream_ctrl.sv
// Directed frame sequence with random pixel data, checked every cycle against a
// frame-timeline model (positions computed from the frame start edge).
module tb_census_stream_ctrl;

    localparam int L    = 8;
    localparam int NL   = 4;
    localparam int WW   = 3;
    localparam int WH   = 3;
    localparam int MD   = 2;
    localparam int PL   = 3;
    localparam int DB   = 2;
    localparam int NPIX = L * NL;
    localparam int NMASK = (NL - (WH - 1)) * (L - (WW + MD - 2));

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_sof = 1'b0;
    logic [7:0]    in_left = '0, in_right = '0;
    logic          in_ready;
    logic [7:0]    dp_left, dp_right;
    logic [DB-1:0] dp_disp;
    logic          out_valid, out_mask, out_sof, out_eol;
    logic [DB-1:0] out_disp;
    logic [2:0]    out_x;
    logic [1:0]    out_y;
    logic          busy, frame_done, err_underrun, err_sof;

    int cyc = 0;
    int checks = 0, errors = 0;

    // Beat presented to each edge, indexed by edge number.
    logic       bv [0:4095];
    logic       bs [0:4095];
    logic [7:0] bl [0:4095];
    logic [7:0] br [0:4095];

    int   k0 = -1000;
    logic m_eu = 1'b0, m_es = 1'b0;
    int   n_valid, n_eol, n_mask, n_done, n_nready, first_valid;

    always #5 clk = ~clk;
    assign dp_disp = DB'(cyc % 4);

    census_stream_ctrl #(
        .LINE_LENGTH(L), .NUM_LINES(NL), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH),
        .MAX_DISPARITY(MD), .PIPE_LATENCY(PL), .DISP_BITS(DB)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_left(in_left), .in_right(in_right), .dp_left(dp_left), .dp_right(dp_right),
        .dp_disp(dp_disp), .out_valid(out_valid), .out_disp(out_disp), .out_mask(out_mask),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .busy(busy),
        .frame_done(frame_done), .err_underrun(err_underrun), .err_sof(err_sof)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A frame occupies NPIX feed cycles, PL+1 flush cycles and one done cycle.
    function automatic bit idle_at(input int c);
        return (c - k0) >= NPIX + PL + 1;
    endfunction

    task automatic chk_all_zero();
        chk("rst_dp_left", dp_left, 0);
        chk("rst_dp_right", dp_right, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_disp", out_disp, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_eol", out_eol, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_underrun", err_underrun, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    task automatic tick();
        int d, o, ex, ey;
        logic ev, emask;
        bv[cyc+1] = in_valid;
        bs[cyc+1] = in_sof;
        bl[cyc+1] = in_left;
        br[cyc+1] = in_right;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            k0 = -1000; m_eu = 1'b0; m_es = 1'b0;
        end else if (idle_at(cyc - 1) && bv[cyc] && bs[cyc]) begin
            k0 = cyc; m_eu = 1'b0; m_es = 1'b0;
        end else if (cyc > k0 && cyc < k0 + NPIX) begin
            if (!bv[cyc])     m_eu = 1'b1;
            else if (bs[cyc]) m_es = 1'b1;
        end
        d = cyc - k0;
        o = d - PL;
        ev = (o >= 0) && (o < NPIX);
        ex = ev ? o % L : 0;
        ey = ev ? o / L : 0;
        emask = ev && (ey >= WH - 1) && (ex >= WW + MD - 2);
        chk("dp_left", dp_left, (d >= 0 && d < NPIX && bv[cyc]) ? bl[cyc] : 0);
        chk("dp_right", dp_right, (d >= 0 && d < NPIX && bv[cyc]) ? br[cyc] : 0);
        chk("in_ready", in_ready, (d >= NPIX - 1 && d <= NPIX + PL) ? 0 : 1);
        chk("busy", busy, (d >= 0 && d <= NPIX + PL) ? 1 : 0);
        chk("out_valid", out_valid, ev);
        chk("out_x", out_x, ex);
        chk("out_y", out_y, ey);
        chk("out_sof", out_sof, ev && o == 0);
        chk("out_eol", out_eol, ev && ex == L - 1);
        chk("out_mask", out_mask, emask);
        chk("out_disp", out_disp, emask ? cyc % 4 : 0);
        chk("frame_done", frame_done, o == NPIX);
        chk("err_underrun", err_underrun, m_eu);
        chk("err_sof", err_sof, m_es);
        if (out_valid === 1'b1) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (out_eol === 1'b1)    n_eol++;
        if (out_mask === 1'b1)   n_mask++;
        if (frame_done === 1'b1) n_done++;
        if (in_ready === 1'b0)   n_nready++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        k0 = -1000; m_eu = 1'b0; m_es = 1'b0;
        chk_all_zero();
        in_valid = 1'b0; in_sof = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic run_frame(input int drop_at, input int drop_len, input int sof_at,
                             input int rst_at);
        n_valid = 0; n_eol = 0; n_mask = 0; n_done = 0; n_nready = 0; first_valid = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            in_valid = !(i >= drop_at && i < drop_at + drop_len);
            in_sof   = (i == 0) || (i == sof_at);
            in_left  = 8'($urandom);
            in_right = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; in_sof = 1'b0;
        for (int i = 0; i < 100 && !idle_at(cyc); i++) tick();
        tick();
        tick();
        // Accept edge k0 to out_valid: PL+1 cycles, i.e. sampled PL edges later.
        chk("first_latency", first_valid - k0, PL);
        chk("n_out_valid", n_valid, NPIX);
        chk("n_out_eol", n_eol, NL);
        chk("n_out_mask", n_mask, NMASK);
        chk("n_frame_done", n_done, 1);
        chk("n_not_ready", n_nready, PL + 2);
    endtask

    initial begin
        #3;
        chk_all_zero();
        tick();
        tick();
        #2 rst = 1'b1;
        tick();

        // Clean frame.
        run_frame(-10, 0, -1, -1);

        // Junk before sof is discarded; busy must stay low through it.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sof = 1'b0;
            in_left = 8'($urandom); in_right = 8'($urandom);
            tick();
        end
        run_frame(-10, 0, -1, -1);

        // Three-cycle underrun in the middle of line 1.
        run_frame(L + int'($urandom_range(2, 4)), 3, -1, -1);
        chk("underrun_sticky", err_underrun, 1);

        // Stray sof mid-frame; error flag, no resync. Also clears the underrun.
        run_frame(-10, 0, 12, -1);
        chk("sof_sticky", err_sof, 1);
        chk("underrun_cleared", err_underrun, 0);

        // Reset mid-frame, then a clean frame.
        run_frame(-10, 0, -1, 20);
        run_frame(-10, 0, -1, -1);
        chk("post_rst_err_sof", err_sof, 0);
        chk("post_rst_err_underrun", err_underrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
